// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes, with bounded waits on both memory handshakes.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                zero,
    multicycle_ctrl_if.master   mem,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                regwrite,
    output logic                regdst,
    output logic                mem2reg,
    output logic                alusrc,
    output logic                extop,
    output logic [3:0]          aluop,
    output logic                error,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_I   = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // The last tolerated wait cycle: a miss here with ready still low times out.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       r_aluop;
    logic             r_legal;
    logic             waiting;
    logic             timed_out;
    logic             imem_req_c;
    logic             dmem_req_c;
    logic             dmem_we_c;

    always_comb begin
        r_aluop = ALU_AND;
        r_legal = 1'b1;
        case (func)
            FN_ADD:  r_aluop = ALU_ADD;
            FN_SUB:  r_aluop = ALU_SUB;
            FN_AND:  r_aluop = ALU_AND;
            FN_OR:   r_aluop = ALU_OR;
            FN_SLT:  r_aluop = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        waiting = 1'b0;
        case (cur)
            S_FETCH:            waiting = !mem.imem_ready;
            S_MEM_RD, S_MEM_WR: waiting = !mem.dmem_ready;
            default:            waiting = 1'b0;
        endcase
    end

    assign timed_out = waiting && (wait_cnt == WAIT_LAST);

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH: begin
                if (mem.imem_ready)  nxt = S_DECODE;
                else if (timed_out)  nxt = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt = S_EXEC_R;
                    OP_ADDI:      nxt = S_EXEC_I;
                    OP_LW, OP_SW: nxt = S_ADDR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_ERROR;
                endcase
            end
            S_EXEC_R: nxt = r_legal ? S_WB_R : S_ERROR;
            S_EXEC_I: nxt = S_WB_I;
            S_ADDR:   nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem.dmem_ready)  nxt = S_WB_MEM;
                else if (timed_out)  nxt = S_ERROR;
            end
            S_MEM_WR: begin
                if (mem.dmem_ready)  nxt = S_FETCH;
                else if (timed_out)  nxt = S_ERROR;
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_ERROR:  nxt = S_ERROR;
            default:  nxt = S_ERROR;
        endcase
    end

    // Counter restarts on every state change, so each wait state sees a fresh budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Strobes are forced low while rst is high so a pending request drops at once.
    always_comb begin
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        mem2reg    = 1'b0;
        alusrc     = 1'b0;
        extop      = 1'b0;
        aluop      = ALU_AND;
        error      = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    imem_req_c = 1'b1;
                    ir_write   = mem.imem_ready;
                    pc_write   = mem.imem_ready;
                    pc_src     = PC_SEQ;
                end
                S_EXEC_R: begin
                    aluop  = r_aluop;
                    alusrc = 1'b0;
                end
                S_EXEC_I, S_ADDR: begin
                    aluop  = ALU_ADD;
                    alusrc = 1'b1;
                    extop  = 1'b1;
                end
                S_MEM_RD: begin
                    dmem_req_c = 1'b1;
                    aluop      = ALU_ADD;
                    alusrc     = 1'b1;
                    extop      = 1'b1;
                end
                S_MEM_WR: begin
                    dmem_req_c = 1'b1;
                    dmem_we_c  = 1'b1;
                end
                S_WB_R: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_WB_I: begin
                    regwrite = 1'b1;
                end
                S_WB_MEM: begin
                    regwrite = 1'b1;
                    mem2reg  = 1'b1;
                end
                S_BRANCH: begin
                    aluop    = ALU_SUB;
                    alusrc   = 1'b0;
                    pc_write = zero;
                    pc_src   = PC_BRANCH;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
                S_ERROR: begin
                    error = 1'b1;
                end
                default: begin
                    error = 1'b0;
                end
            endcase
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign state        = cur;

endmodule
